alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 29 ++
 rtl/alu_mc_iter.sv | 68 ++++++
 rtl/alu_mc.sv | 130 +++++++++++++
 tb/tb_alu_mc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// bit positions inside the flags word.
package alu_mc_pkg;

   localparam logic [3:0] OP_NOT  = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_NAND = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_NOR  = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_XNOR = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_ADD  = 4'h8;
   localparam logic [3:0] OP_SUB  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_DIV  = 4'hB;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;
   localparam int FLAG_ERR   = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one step
// per cycle. The next-step values are exported so the top can capture them on the
// final step.
module alu_mc_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo_nxt,
   output logic [WIDTH-1:0] hi_nxt,
   output logic             last
);
   import alu_mc_pkg::*;

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc, sh, opnd;
   logic [WIDTH-1:0] acc_nxt, sh_nxt;
   logic [WIDTH:0]   sum, trial;
   logic             div_mode;
   logic [CW-1:0]    cnt;

   // acc is the product high half / partial remainder; sh holds multiplier or dividend/quotient
   always_comb begin
      sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
      trial = {acc, sh[WIDTH-1]} - {1'b0, opnd};
      if (div_mode) begin
         if (!trial[WIDTH]) begin
            acc_nxt = trial[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = {acc[WIDTH-2:0], sh[WIDTH-1]};
            sh_nxt  = {sh[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nxt = sum[WIDTH:1];
         sh_nxt  = {sum[0], sh[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         acc      <= '0;
         sh       <= a;
         opnd     <= b;
         div_mode <= is_div;
      end else if (step) begin
         acc <= acc_nxt;
         sh  <= sh_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt <= '0;
      else if (load)   cnt <= '0;
      else if (step)   cnt <= cnt + 1'b1;
   end

   assign last   = (cnt == CW'(WIDTH - 1));
   assign lo_nxt = sh_nxt;
   assign hi_nxt = acc_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle logic/shift/add/sub, output
// registers, and the iterative MUL/DIV unit.
module alu_mc #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);
   import alu_mc_pkg::*;

   localparam int M = WIDTH - 1;

   state_t           state, state_nxt;
   logic             accept, iterative, last;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] it_lo, it_hi, sc_res, sc_hi;
   logic [3:0]       sc_flags, it_flags;
   logic [WIDTH:0]   add_w, sub_w;

   assign accept    = in_valid && in_ready;
   assign iterative = (op_code == OP_MUL) || ((op_code == OP_DIV) && (b != '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)    state_nxt = iterative ? S_BUSY : S_DONE;
         S_BUSY:  if (last)      state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   // DIV only reaches this path with b == 0; MUL never does
   always_comb begin
      add_w    = {1'b0, a} + {1'b0, b};
      sub_w    = {1'b0, a} - {1'b0, b};
      sc_res   = '0;
      sc_hi    = '0;
      sc_flags = '0;
      case (op_code)
         OP_NOT:  sc_res = ~a;
         OP_AND:  sc_res = a & b;
         OP_NAND: sc_res = ~(a & b);
         OP_OR:   sc_res = a | b;
         OP_NOR:  sc_res = ~(a | b);
         OP_XOR:  sc_res = a ^ b;
         OP_XNOR: sc_res = ~(a ^ b);
         OP_SHL:  sc_res = a << b[SHW-1:0];
         OP_ADD: begin
            sc_res              = add_w[M:0];
            sc_flags[FLAG_CARRY] = add_w[WIDTH];
            sc_flags[FLAG_OVF]   = (a[M] == b[M]) && (add_w[M] != a[M]);
         end
         OP_SUB: begin
            sc_res              = sub_w[M:0];
            sc_flags[FLAG_CARRY] = sub_w[WIDTH];
            sc_flags[FLAG_OVF]   = (a[M] != b[M]) && (sub_w[M] != a[M]);
         end
         OP_MUL:  sc_res = '0;
         OP_DIV: begin
            sc_res             = '1;
            sc_hi              = a;
            sc_flags[FLAG_ERR] = 1'b1;
         end
         default: sc_flags[FLAG_ERR] = 1'b1;
      endcase
      sc_flags[FLAG_ZERO] = (sc_res == '0);
   end

   always_comb begin
      it_flags            = '0;
      it_flags[FLAG_ZERO] = (it_lo == '0);
      it_flags[FLAG_OVF]  = (op_q == OP_MUL) && (it_hi != '0);
   end

   always_ff @(posedge clk) begin
      if (accept) op_q <= op_code;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         result_hi <= '0;
         flags     <= '0;
      end else if (accept && !iterative) begin
         result    <= sc_res;
         result_hi <= sc_hi;
         flags     <= sc_flags;
      end else if ((state == S_BUSY) && last) begin
         result    <= it_lo;
         result_hi <= it_hi;
         flags     <= it_flags;
      end
   end

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept && iterative),
      .step   (state == S_BUSY),
      .is_div (op_code == OP_DIV),
      .a      (a),
      .b      (b),
      .lo_nxt (it_lo),
      .hi_nxt (it_hi),
      .last   (last)
   );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8: directed corner cases, randomized ops against an
// arithmetic reference model, backpressure and reset-abort scenarios.
module tb_alu_mc;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op_code = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result, result_hi;
   logic [3:0]   flags;

   int n_cmp = 0;
   int n_err = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_code   (op_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   // reference: flags = {err, ovf, carry, zero}; lat counts edges from acceptance to out_valid
   function automatic void model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                 output logic [7:0] r, output logic [7:0] h,
                                 output logic [3:0] f, output int lat);
      int unsigned ux, uy, p;
      int sx, sy, s;
      logic err, ovf, cy;
      ux = 32'(x); uy = 32'(y);
      sx = int'($signed(x)); sy = int'($signed(y));
      r = '0; h = '0; err = 1'b0; ovf = 1'b0; cy = 1'b0; lat = 1;
      case (op)
         4'h0: r = ~x;
         4'h1: r = x & y;
         4'h2: r = ~(x & y);
         4'h3: r = x | y;
         4'h4: r = ~(x | y);
         4'h5: r = x ^ y;
         4'h6: r = ~(x ^ y);
         4'h7: r = 8'(ux << (uy % 8));
         4'h8: begin
            p = ux + uy; r = 8'(p); cy = (p > 255);
            s = sx + sy; ovf = (s > 127) || (s < -128);
         end
         4'h9: begin
            r = 8'(ux - uy); cy = (ux < uy);
            s = sx - sy; ovf = (s > 127) || (s < -128);
         end
         4'hA: begin
            p = ux * uy; r = 8'(p); h = 8'(p >> 8); ovf = (h != 8'd0); lat = W + 1;
         end
         4'hB: begin
            if (uy == 0) begin
               r = 8'hFF; h = x; err = 1'b1;
            end else begin
               r = 8'(ux / uy); h = 8'(ux % uy); lat = W + 1;
            end
         end
         default: err = 1'b1;
      endcase
      f = {err, ovf, cy, (r == 8'd0)};
   endfunction

   // Present one operation, scramble inputs after acceptance, wait (bounded) for out_valid.
   task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output bit rdy_busy);
      @(negedge clk);
      op_code = op; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op_code = 4'($urandom);
      lat = 1; rdy_busy = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) rdy_busy = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if ({result, result_hi, flags} !== 20'h0) begin
         n_err++; $display("FAIL reset_outputs got %h/%h/%b want 0/0/0", result, result_hi, flags);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [3:0] t_op [8];
      logic [7:0] t_a [8], t_b [8], t_r [8], t_h [8];
      logic [3:0] t_f [8];
      int         t_l [8];
      int         lat;
      bit         rb;
      t_op = '{4'h8, 4'h9, 4'h9, 4'hA, 4'hB, 4'hB, 4'h7, 4'h7};
      t_a  = '{8'hF0, 8'h80, 8'h05, 8'hFF, 8'h64, 8'h64, 8'hA5, 8'hA5};
      t_b  = '{8'h20, 8'h01, 8'h05, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h0B};
      t_r  = '{8'h10, 8'h7F, 8'h00, 8'h01, 8'h0E, 8'hFF, 8'hA5, 8'h28};
      t_h  = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h02, 8'h64, 8'h00, 8'h00};
      t_f  = '{4'b0010, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      t_l  = '{1, 1, 1, 9, 9, 1, 1, 1};
      for (int i = 0; i < 8; i++) begin
         issue(t_op[i], t_a[i], t_b[i], lat, rb);
         n_cmp++; if (lat !== t_l[i]) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t_l[i]); end
         n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_ready got 1 want 0", i); end
         n_cmp++; if ({result_hi, result} !== {t_h[i], t_r[i]}) begin
            n_err++; $display("FAIL dir%0d_result got %h%h want %h%h", i, result_hi, result, t_h[i], t_r[i]);
         end
         n_cmp++; if (flags !== t_f[i]) begin n_err++; $display("FAIL dir%0d_flags got %b want %b", i, flags, t_f[i]); end
         drain();
      end
   endtask

   task automatic test_random;
      logic [3:0] op;
      logic [7:0] x, y, er, eh;
      logic [3:0] ef;
      int         el, lat;
      bit         rb;
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         x  = 8'($urandom);
         y  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         model(op, x, y, er, eh, ef, el);
         issue(op, x, y, lat, rb);
         n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rnd%0d_latency op=%h got %0d want %0d", i, op, lat, el); end
         n_cmp++; if ({result_hi, result, flags} !== {eh, er, ef}) begin
            n_err++;
            $display("FAIL rnd%0d_out op=%h a=%h b=%h got %h/%h/%b want %h/%h/%b",
                     i, op, x, y, result_hi, result, flags, eh, er, ef);
         end
         drain();
      end
   endtask

   task automatic test_backpressure;
      logic [7:0] er, eh;
      logic [3:0] ef;
      int         el, lat;
      bit         rb;
      model(4'h8, 8'h3C, 8'h4D, er, eh, ef, el);
      issue(4'h8, 8'h3C, 8'h4D, lat, rb);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op_code = 4'h9; a = 8'($urandom); b = 8'($urandom);
         @(posedge clk); #1;
         n_cmp++; if ({out_valid, in_ready, result_hi, result, flags} !== {1'b1, 1'b0, eh, er, ef}) begin
            n_err++;
            $display("FAIL bp_hold%0d got v=%b r=%b %h/%h/%b want v=1 r=0 %h/%h/%b",
                     i, out_valid, in_ready, result_hi, result, flags, eh, er, ef);
         end
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      @(negedge clk); out_ready = 1'b0;
      model(4'h5, 8'h5A, 8'h0F, er, eh, ef, el);
      issue(4'h5, 8'h5A, 8'h0F, lat, rb);
      n_cmp++; if ({lat == 1, result_hi, result, flags} !== {1'b1, eh, er, ef}) begin
         n_err++; $display("FAIL bp_next_op got lat=%0d %h/%h/%b want lat=1 %h/%h/%b",
                           lat, result_hi, result, flags, eh, er, ef);
      end
      drain();
   endtask

   task automatic test_reset_abort;
      int  lat;
      bit  rb, seen;
      @(negedge clk);
      op_code = 4'hA; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      n_cmp++; if ({out_valid, result, result_hi, flags} !== 21'h0) begin
         n_err++; $display("FAIL abort_outputs got v=%b %h/%h/%b want all 0", out_valid, result, result_hi, flags);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_result got out_valid=1 want 0"); end
      issue(4'hF, 8'h12, 8'h34, lat, rb);
      n_cmp++; if ({lat == 1, result_hi, result, flags} !== {1'b1, 8'h00, 8'h00, 4'b1001}) begin
         n_err++; $display("FAIL abort_illegal got lat=%0d %h/%h/%b want lat=1 00/00/1001",
                           lat, result_hi, result, flags);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
